// File: rtl/dm_sba_arbiter_if.sv
// rtl/dm_sba_arbiter_if.sv - requester-side and system-bus-side signals of the SBA arbiter
interface dm_sba_arbiter_if #(
  parameter int NrMasters = 2,
  parameter int BusWidth  = 32
);
  logic [NrMasters-1:0]                   req_i;
  logic [NrMasters-1:0]                   we_i;
  logic [NrMasters-1:0][BusWidth-1:0]     add_i;
  logic [NrMasters-1:0][BusWidth-1:0]     wdata_i;
  logic [NrMasters-1:0][BusWidth/8-1:0]   be_i;
  logic [NrMasters-1:0]                   gnt_o;
  logic [NrMasters-1:0]                   r_valid_o;
  logic                                   r_err_o;
  logic                                   r_other_err_o;
  logic [BusWidth-1:0]                    r_rdata_o;
  logic                                   master_req_o;
  logic                                   master_we_o;
  logic [BusWidth-1:0]                    master_add_o;
  logic [BusWidth-1:0]                    master_wdata_o;
  logic [BusWidth/8-1:0]                  master_be_o;
  logic                                   master_gnt_i;
  logic                                   master_r_valid_i;
  logic                                   master_r_err_i;
  logic                                   master_r_other_err_i;
  logic [BusWidth-1:0]                    master_r_rdata_i;
  logic                                   busy_o;

  // arbiter view: owns the downstream master port
  modport master (
    input  req_i, we_i, add_i, wdata_i, be_i,
    input  master_gnt_i, master_r_valid_i, master_r_err_i, master_r_other_err_i, master_r_rdata_i,
    output gnt_o, r_valid_o, r_err_o, r_other_err_o, r_rdata_o,
    output master_req_o, master_we_o, master_add_o, master_wdata_o, master_be_o, busy_o
  );

  modport slave (
    output req_i, we_i, add_i, wdata_i, be_i,
    output master_gnt_i, master_r_valid_i, master_r_err_i, master_r_other_err_i, master_r_rdata_i,
    input  gnt_o, r_valid_o, r_err_o, r_other_err_o, r_rdata_o,
    input  master_req_o, master_we_o, master_add_o, master_wdata_o, master_be_o, busy_o
  );
endinterface

// File: rtl/dm_sba_arbiter.sv
// rtl/dm_sba_arbiter.sv - round-robin sharing of one SBA bus master port, one transaction in flight
// Optional response watchdog enabled by DM_SBA_ARB_TIMEOUT_EN.
module dm_sba_arbiter #(
  parameter int NrMasters     = 2,
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 1024
) (
  input logic              clk_i,
  input logic              rst_i,
  dm_sba_arbiter_if.master bus
);
  localparam int SelW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam logic [SelW-1:0] LastSel = SelW'(NrMasters - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d, ptr_q, ptr_d, winner, idx;
  logic [SelW:0]   sum;
  logic            timeout;

  // Scan downwards so the requester closest after ptr_q is the last (winning) hit.
  always_comb begin
    winner = '0;
    idx    = '0;
    sum    = '0;
    for (int k = NrMasters - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (SelW+1)'(k);
      if (sum >= (SelW+1)'(NrMasters)) sum = sum - (SelW+1)'(NrMasters);
      idx = sum[SelW-1:0];
      if (bus.req_i[idx]) winner = idx;
    end
  end

`ifdef DM_SBA_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    cnt_q <= '0;
    else if (state_q != RESP)     cnt_q <= '0;
    else if (!bus.master_r_valid_i) cnt_q <= cnt_q + CntW'(1);
  end

  assign timeout = (state_q == RESP) && !bus.master_r_valid_i &&
                   (cnt_q == CntW'(TimeoutCycles - 1));
`else
  // watchdog parameter is inert without the macro
  assign timeout = (TimeoutCycles < 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    sel_d                  = sel_q;
    ptr_d                  = ptr_q;
    bus.gnt_o              = '0;
    bus.r_valid_o          = '0;
    bus.r_err_o            = 1'b0;
    bus.r_other_err_o      = 1'b0;
    bus.r_rdata_o          = '0;
    bus.master_req_o       = 1'b0;
    bus.master_we_o        = 1'b0;
    bus.master_add_o       = '0;
    bus.master_wdata_o     = '0;
    bus.master_be_o        = '0;
    bus.busy_o             = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          sel_d   = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.master_req_o      = bus.req_i[sel_q];
        bus.master_we_o       = bus.we_i[sel_q];
        bus.master_add_o      = bus.add_i[sel_q];
        bus.master_wdata_o    = bus.wdata_i[sel_q];
        bus.master_be_o       = bus.be_i[sel_q];
        bus.gnt_o[sel_q]      = bus.master_gnt_i;
        if (bus.req_i[sel_q] && bus.master_gnt_i) begin
          state_d = RESP;
          ptr_d   = (sel_q == LastSel) ? '0 : sel_q + SelW'(1);
        end else if (!bus.req_i[sel_q]) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        bus.r_rdata_o     = bus.master_r_rdata_i;
        bus.r_err_o       = bus.master_r_err_i;
        bus.r_other_err_o = bus.master_r_other_err_i;
        if (bus.master_r_valid_i) begin
          bus.r_valid_o[sel_q] = 1'b1;
          state_d              = IDLE;
        end else if (timeout) begin
          bus.r_valid_o[sel_q] = 1'b1;
          bus.r_other_err_o    = 1'b1;
          bus.r_err_o          = 1'b0;
          bus.r_rdata_o        = '0;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dm_sba_arbiter.sv
// tb/tb_dm_sba_arbiter.sv - directed vector table, corner sequences and random run against a reference model
module tb_dm_sba_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 8;
`ifdef DM_SBA_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_sba_arbiter_if #(.NrMasters(N), .BusWidth(W)) bus ();
  dm_sba_arbiter #(.NrMasters(N), .BusWidth(W), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct packed {
    logic        mreq;
    logic        mwe;
    logic [31:0] madd;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        err;
    logic        oerr;
    logic [31:0] rdata;
    logic        busy;
  } out_t;

  typedef struct {
    logic [1:0]  req;
    logic        gnt, rv, err;
    logic [31:0] rdata;
    logic        mreq;
    int          psel;
    logic [1:0]  egnt, erv;
    logic        eerr, eoerr;
    logic [31:0] erdata;
    logic        busy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] b_req;
  logic         b_gnt, b_rv, b_err, b_oerr;
  logic [31:0]  b_rdata;
  logic [N-1:0] p_we;
  logic [31:0]  p_add[N];
  logic [31:0]  p_wdata[N];
  logic [3:0]   p_be[N];

  int m_own, m_ptr, m_wait;
  bit m_gr;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.req_i                = b_req;
    bus.we_i                 = p_we;
    for (int i = 0; i < N; i++) begin
      bus.add_i[i]   = p_add[i];
      bus.wdata_i[i] = p_wdata[i];
      bus.be_i[i]    = p_be[i];
    end
    bus.master_gnt_i         = b_gnt;
    bus.master_r_valid_i     = b_rv;
    bus.master_r_err_i       = b_err;
    bus.master_r_other_err_i = b_oerr;
    bus.master_r_rdata_i     = b_rdata;
  endtask

  function automatic out_t sample();
    out_t o;
    o.mreq   = bus.master_req_o;
    o.mwe    = bus.master_we_o;
    o.madd   = bus.master_add_o;
    o.mwdata = bus.master_wdata_o;
    o.mbe    = bus.master_be_o;
    o.gnt    = bus.gnt_o;
    o.rv     = bus.r_valid_o;
    o.err    = bus.r_err_o;
    o.oerr   = bus.r_other_err_o;
    o.rdata  = bus.r_rdata_o;
    o.busy   = bus.busy_o;
    return o;
  endfunction

  function automatic vec_t v(logic [1:0] req, logic gnt, logic rv, logic err, logic [31:0] rdata,
                             logic mreq, int psel, logic [1:0] egnt, logic [1:0] erv,
                             logic eerr, logic eoerr, logic [31:0] erdata, logic busy);
    vec_t t;
    t.req = req; t.gnt = gnt; t.rv = rv; t.err = err; t.rdata = rdata;
    t.mreq = mreq; t.psel = psel; t.egnt = egnt; t.erv = erv;
    t.eerr = eerr; t.eoerr = eoerr; t.erdata = erdata; t.busy = busy;
    return t;
  endfunction

  function automatic vec_t z(logic [1:0] req, logic gnt, logic rv, logic err, logic [31:0] rdata);
    return v(req, gnt, rv, err, rdata, 1'b0, -1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
  endfunction

  task automatic apply(vec_t t, string name);
    out_t e;
    @(negedge clk);
    b_req = t.req; b_gnt = t.gnt; b_rv = t.rv; b_err = t.err; b_oerr = 1'b0; b_rdata = t.rdata;
    drive();
    #1;
    e = '0;
    e.mreq = t.mreq;
    if (t.psel >= 0) begin
      e.mwe = p_we[t.psel]; e.madd = p_add[t.psel]; e.mwdata = p_wdata[t.psel]; e.mbe = p_be[t.psel];
    end
    e.gnt = t.egnt; e.rv = t.erv; e.err = t.eerr; e.oerr = t.eoerr; e.rdata = t.erdata; e.busy = t.busy;
    chk(name, sample(), e);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    b_req = '0; b_gnt = 0; b_rv = 0; b_err = 0; b_oerr = 0; b_rdata = '0;
    drive();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_payload(int i);
    p_we[i] = 1'($urandom_range(0, 1));
    p_add[i] = $urandom; p_wdata[i] = $urandom; p_be[i] = 4'($urandom_range(0, 15));
  endtask

  // Reference: owner index (-1 when free), granted flag, rotating start point.
  function automatic out_t model_out();
    out_t o = '0;
    if (m_own >= 0) begin
      o.busy = 1'b1;
      if (!m_gr) begin
        o.mreq = b_req[m_own]; o.mwe = p_we[m_own]; o.madd = p_add[m_own];
        o.mwdata = p_wdata[m_own]; o.mbe = p_be[m_own]; o.gnt[m_own] = b_gnt;
      end else begin
        o.rdata = b_rdata; o.err = b_err; o.oerr = b_oerr;
        if (b_rv) o.rv[m_own] = 1'b1;
        else if (TimeoutOn && m_wait == TO - 1) begin
          o.rv[m_own] = 1'b1; o.oerr = 1'b1; o.rdata = '0; o.err = 1'b0;
        end
      end
    end
    return o;
  endfunction

  task automatic model_step();
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (b_req[j]) begin m_own = j; m_gr = 0; break; end
      end
    end else if (!m_gr) begin
      if (b_req[m_own] && b_gnt) begin m_gr = 1; m_ptr = (m_own + 1) % N; m_wait = 0; end
      else if (!b_req[m_own]) m_own = -1;
    end else begin
      if (b_rv || (TimeoutOn && m_wait == TO - 1)) begin m_own = -1; m_gr = 0; end
      else m_wait++;
    end
  endtask

  vec_t tbl[$];

  initial begin
    bit gr_evt, in_resp;
    int own_c, bus_dly;
    bit bus_out;

    p_we = 2'b10;
    p_add[0] = 32'h0000_1000; p_add[1] = 32'h0000_2000;
    p_wdata[0] = 32'h0; p_wdata[1] = 32'hA5A5_A5A5;
    p_be[0] = 4'hF; p_be[1] = 4'hF;
    b_req = 2'b11; b_gnt = 1; b_rv = 1; b_err = 1; b_oerr = 1; b_rdata = 32'hFFFF_FFFF;
    drive();
    #1;
    chk("reset_outputs", sample(), out_t'(0));
    chk("reset_ptr_sel", {dut.ptr_q, dut.sel_q}, 0);
    @(negedge clk);
    rst = 1'b0;
    b_req = '0; b_gnt = 0; b_rv = 0; b_err = 0; b_oerr = 0; b_rdata = '0;
    drive();

    tbl.push_back(z(2'b01, 0, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 0, 0, 0, 32'h0, 1, 0, 2'b00, 2'b00, 0, 0, 32'h0, 1));
    tbl.push_back(v(2'b01, 1, 0, 0, 32'h0, 1, 0, 2'b01, 2'b00, 0, 0, 32'h0, 1));
    tbl.push_back(v(2'b00, 0, 1, 0, 32'hDEADBEEF, 0, -1, 2'b00, 2'b01, 0, 0, 32'hDEADBEEF, 1));
    tbl.push_back(z(2'b00, 0, 0, 0, 32'h0));
    tbl.push_back(z(2'b01, 0, 0, 0, 32'h0));
    tbl.push_back(v(2'b01, 1, 0, 0, 32'h0, 1, 0, 2'b01, 2'b00, 0, 0, 32'h0, 1));
    tbl.push_back(v(2'b11, 0, 0, 0, 32'h0, 0, -1, 2'b00, 2'b00, 0, 0, 32'h0, 1));
    tbl.push_back(v(2'b10, 0, 1, 0, 32'h11111111, 0, -1, 2'b00, 2'b01, 0, 0, 32'h11111111, 1));
    tbl.push_back(z(2'b10, 0, 0, 0, 32'h0));
    tbl.push_back(v(2'b10, 1, 0, 0, 32'h0, 1, 1, 2'b10, 2'b00, 0, 0, 32'h0, 1));
    tbl.push_back(v(2'b00, 0, 1, 1, 32'h0, 0, -1, 2'b00, 2'b10, 1, 0, 32'h0, 1));
    tbl.push_back(z(2'b00, 0, 0, 0, 32'h0));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(z(2'b11, 1, 1, 0, 32'h12345678));
      tbl.push_back(v(2'b11, 1, 1, 0, 32'h12345678, 1, 0, 2'b01, 2'b00, 0, 0, 32'h0, 1));
      tbl.push_back(v(2'b11, 1, 1, 0, 32'h12345678, 0, -1, 2'b00, 2'b01, 0, 0, 32'h12345678, 1));
      tbl.push_back(z(2'b11, 1, 1, 0, 32'h12345678));
      tbl.push_back(v(2'b11, 1, 1, 0, 32'h12345678, 1, 1, 2'b10, 2'b00, 0, 0, 32'h0, 1));
      tbl.push_back(v(2'b11, 1, 1, 0, 32'h12345678, 0, -1, 2'b00, 2'b10, 0, 0, 32'h12345678, 1));
    end
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (i == 4) chk("ptr_after_single_read", 128'(dut.ptr_q), 128'(1));
    end

    // requester drops before grant: no grant, pointer untouched
    reset_dut();
    apply(z(2'b01, 0, 0, 0, 32'h0), "drop_idle");
    apply(v(2'b00, 0, 0, 0, 32'h0, 0, 0, 2'b00, 2'b00, 0, 0, 32'h0, 1), "drop_req");
    apply(z(2'b00, 0, 0, 0, 32'h0), "drop_back_idle");
    chk("drop_ptr", 128'(dut.ptr_q), 128'(0));
    apply(z(2'b11, 0, 0, 0, 32'h0), "drop_rearb_idle");
    apply(v(2'b11, 0, 0, 0, 32'h0, 1, 0, 2'b00, 2'b00, 0, 0, 32'h0, 1), "drop_rearb_sel0");
    apply(v(2'b11, 1, 0, 0, 32'h0, 1, 0, 2'b01, 2'b00, 0, 0, 32'h0, 1), "rst_setup_gnt");

    // asynchronous reset while the response is pending
    @(negedge clk);
    b_req = '0; b_gnt = 0; b_rv = 1; b_rdata = 32'hCAFEF00D;
    drive();
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", sample(), out_t'(0));
    chk("async_rst_ptr", 128'(dut.ptr_q), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    apply(z(2'b00, 0, 1, 0, 32'hCAFEF00D), "post_rst_rv0");
    apply(z(2'b00, 0, 1, 0, 32'hCAFEF00D), "post_rst_rv1");

`ifdef DM_SBA_ARB_TIMEOUT_EN
    reset_dut();
    apply(z(2'b01, 0, 0, 0, 32'h0), "to_idle");
    apply(v(2'b01, 1, 0, 0, 32'h0, 1, 0, 2'b01, 2'b00, 0, 0, 32'h0, 1), "to_gnt");
    for (int c = 1; c < TO; c++)
      apply(v(2'b00, 0, 0, 0, 32'h77777777, 0, -1, 2'b00, 2'b00, 0, 0, 32'h77777777, 1),
            $sformatf("to_wait%0d", c));
    apply(v(2'b00, 0, 0, 0, 32'h77777777, 0, -1, 2'b00, 2'b01, 0, 1, 32'h0, 1), "to_fire");
    apply(z(2'b00, 0, 1, 0, 32'h77777777), "to_late_rv");
`endif

    // randomized traffic against the reference model
    reset_dut();
    m_own = -1; m_ptr = 0; m_gr = 0; m_wait = 0;
    bus_out = 0; bus_dly = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!b_req[i]) begin
          if ($urandom_range(0, 2) == 0) begin b_req[i] = 1'b1; new_payload(i); end
        end else if (!(m_own == i && m_gr) && $urandom_range(0, 19) == 0) begin
          b_req[i] = 1'b0;
        end
      end
      b_gnt = (m_own >= 0 && !m_gr && b_req[m_own]) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus_out) b_rv = (bus_dly == 0);
      else         b_rv = ($urandom_range(0, 9) == 0);
      b_rdata = $urandom; b_err = 1'($urandom_range(0, 1)); b_oerr = 1'($urandom_range(0, 1));
      drive();
      #1;
      chk($sformatf("rand%0d", cyc), sample(), model_out());
      @(posedge clk);
      gr_evt  = (m_own >= 0 && !m_gr && b_req[m_own] && b_gnt);
      in_resp = (m_own >= 0 && m_gr);
      own_c   = m_own;
      model_step();
      if (gr_evt) begin
        bus_out = 1; bus_dly = $urandom_range(0, 3);
        b_req[own_c] = 1'($urandom_range(0, 1));
        if (b_req[own_c]) new_payload(own_c);
      end else if (in_resp && b_rv) begin
        bus_out = 0;
      end else if (in_resp) begin
        bus_dly--;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
